// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer
//   Small synchronous FIFO between the instruction-memory fetch port and the
//   decode stage. Each entry holds a 32-bit instruction word and its address.
//   The head entry is presented combinationally; when the buffer is empty the
//   outputs show NOP_INSTR / 0, so no storage X can reach decode.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-low reset
//   flush      discard all entries (branch redirect / trap)
//   in_valid   fetch presents a word this cycle
//   in_instr   fetched instruction word (bit 0 = MSB)
//   in_ia      instruction address of in_instr
//   in_ready   buffer can accept a word (registered count only)
//   out_valid  head entry valid
//   out_instr  head instruction word, NOP_INSTR when empty
//   out_ia     head instruction address, 0 when empty
//   out_ready  decode consumes the head this cycle
//   count      current occupancy, 0..DEPTH
module instr_fetch_buffer #(
  parameter int unsigned  DEPTH     = 4,
  parameter int unsigned  PTR_W     = 2,
  parameter logic [0:31]  NOP_INSTR = 32'h0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  input  logic [0:31]    in_instr,
  input  logic [0:31]    in_ia,
  output logic           in_ready,
  output logic           out_valid,
  output logic [0:31]    out_instr,
  output logic [0:31]    out_ia,
  input  logic           out_ready,
  output logic [0:PTR_W] count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [0:31]      instr_q [DEPTH];
  logic [0:31]      ia_q    [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             push, pop;

  // Handshake flags come from registered count only, so out_ready never
  // reaches in_ready combinationally; a pop while full cannot admit a push.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_instr = out_valid ? instr_q[rd_ptr_q] : NOP_INSTR;
  assign out_ia    = out_valid ? ia_q[rd_ptr_q]    : '0;
  assign count     = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; outputs are gated by count instead.
  always_ff @(posedge clk) begin
    if (rst && !flush && push) begin
      instr_q[wr_ptr_q] <= in_instr;
      ia_q[wr_ptr_q]    <= in_ia;
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
module tb_instr_fetch_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
  localparam logic [31:0] NOP   = 32'h0;

  logic           clk;
  logic           rst;
  logic           flush;
  logic           in_valid;
  logic [0:31]    in_instr;
  logic [0:31]    in_ia;
  logic           in_ready;
  logic           out_valid;
  logic [0:31]    out_instr;
  logic [0:31]    out_ia;
  logic           out_ready;
  logic [0:PTR_W] count;

  instr_fetch_buffer #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_instr(in_instr),
    .in_ia(in_ia),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_ia(out_ia),
    .out_ready(out_ready),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of {instr, ia}, head at index 0.
  logic [63:0] mq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int n;
    logic [31:0] ei, ea;
    n  = mq.size();
    ei = (n != 0) ? mq[0][63:32] : NOP;
    ea = (n != 0) ? mq[0][31:0]  : 32'h0;
    chk("count",     32'(count),     32'(n));
    chk("out_valid", 32'(out_valid), 32'(n != 0));
    chk("in_ready",  32'(in_ready),  32'(n != DEPTH));
    chk("out_instr", out_instr,      ei);
    chk("out_ia",    out_ia,         ea);
  endtask

  // Called at a negedge: checks outputs, drives inputs, advances the model,
  // then returns at the following negedge.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [31:0] ins, input logic [31:0] ia,
                      input logic ordy, input bit do_chk);
    bit do_push, do_pop;
    if (do_chk) check_outputs();
    rst = r; flush = f; in_valid = iv; in_instr = ins; in_ia = ia; out_ready = ordy;
    do_push = iv && (mq.size() != DEPTH);
    do_pop  = (mq.size() != 0) && ordy;
    if (!r || f) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({ins, ia});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b1, 1'b0, 1'b0, $urandom, $urandom, ordy, 1'b1);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_ia = '0;
    @(negedge clk);

    // 1. reset held two cycles with in_valid high
    step(1'b0, 1'b0, 1'b1, 32'h11111111, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h22222222, 32'h4, 1'b0, 1'b0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 2. single pass
    step(1'b1, 1'b0, 1'b1, 32'hC0FFEE01, 32'h00001000, 1'b0, 1'b1);
    chk("t2_head", out_instr, 32'hC0FFEE01);
    chk("t2_ia", out_ia, 32'h00001000);
    chk("t2_count", 32'(count), 32'd1);
    idle(1'b1);
    chk("t2_empty_count", 32'(count), 32'd0);
    chk("t2_empty_instr", out_instr, 32'h0);

    // 3. fill and overflow
    for (int i = 1; i <= 5; i++)
      step(1'b1, 1'b0, 1'b1, 32'(i), 32'(i * 4), 1'b0, 1'b1);
    chk("t3_full_count", 32'(count), 32'd4);
    chk("t3_full_ready", 32'(in_ready), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      chk("t3_drain", out_instr, 32'(i));
      idle(1'b1);
    end
    chk("t3_drained", 32'(count), 32'd0);

    // 4. streaming with wrap-around
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b1, 32'hA0 + 32'(i), 32'h100 + 32'(i), 1'b1, 1'b1);
      chk("t4_stream_head", out_instr, 32'hA0 + 32'(i));
      chk("t4_stream_count", 32'(count), 32'd1);
    end
    idle(1'b1);

    // 5. full plus simultaneous pop
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b1, 32'hB0 + 32'(i), 32'h200 + 32'(i), 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'hB4, 32'h204, 1'b1, 1'b1);
    chk("t5_pop_full", 32'(count), 32'd3);
    chk("t5_head", out_instr, 32'hB1);
    step(1'b1, 1'b0, 1'b1, 32'hB4, 32'h204, 1'b1, 1'b1);
    chk("t5_push_pop", 32'(count), 32'd3);

    // 6. flush mid-stream
    step(1'b1, 1'b1, 1'b1, 32'hDEAD0000, 32'h300, 1'b0, 1'b1);
    chk("t6_flush_count", 32'(count), 32'd0);
    chk("t6_flush_valid", 32'(out_valid), 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'hBEEF0000, 32'h00002000, 1'b0, 1'b1);
    chk("t6_head", out_instr, 32'hBEEF0000);
    chk("t6_ia", out_ia, 32'h00002000);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic r, f;
      r = ($urandom_range(0, 99) >= 2);
      f = ($urandom_range(0, 99) < 5);
      step(r, f, 1'($urandom), $urandom, $urandom, 1'($urandom), 1'b1);
    end
    check_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
